// File: rtl/gemm_uop_loader_pkg.sv
// Shared field map for GEMM instructions and micro-ops, plus the loader state encoding.
// Used by the loader, the instruction packer and the benches.
package gemm_uop_loader_pkg;

   // GEMM instruction fields
   localparam int unsigned OPCODE_LSB         = 0;
   localparam int unsigned OPCODE_W           = 3;
   localparam int unsigned RESET_REG_BIT      = 7;
   localparam int unsigned UOP_BGN_LSB        = 8;
   localparam int unsigned UOP_BGN_W          = 13;
   localparam int unsigned UOP_END_LSB        = 21;
   localparam int unsigned UOP_END_W          = 14;
   localparam int unsigned ITER_OUT_LSB       = 35;
   localparam int unsigned ITER_OUT_W         = 14;
   localparam int unsigned ITER_IN_LSB        = 49;
   localparam int unsigned ITER_IN_W          = 14;
   localparam int unsigned DST_FACTOR_OUT_LSB = 63;
   localparam int unsigned DST_FACTOR_IN_LSB  = 74;
   localparam int unsigned SRC_FACTOR_OUT_LSB = 85;
   localparam int unsigned SRC_FACTOR_IN_LSB  = 96;
   localparam int unsigned ACC_FACTOR_W       = 11;
   localparam int unsigned WGT_FACTOR_OUT_LSB = 107;
   localparam int unsigned WGT_FACTOR_IN_LSB  = 117;
   localparam int unsigned WGT_FACTOR_W       = 10;

   // Micro-op fields
   localparam int unsigned UOP_ACC_LSB = 0;
   localparam int unsigned UOP_ACC_W   = 11;
   localparam int unsigned UOP_INP_LSB = 11;
   localparam int unsigned UOP_INP_W   = 11;
   localparam int unsigned UOP_WGT_LSB = 22;
   localparam int unsigned UOP_WGT_W   = 10;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StFlush = 2'd2,
      StIssue = 2'd3
   } loader_state_e;

endpackage

// File: rtl/gemm_insn_pack.sv
// Merges an instruction template with the uop_bgn/uop_end range into a GEMM instruction.
module gemm_insn_pack
   import gemm_uop_loader_pkg::*;
#(
   parameter int unsigned INS_WIDTH = 128
) (
   input  logic [INS_WIDTH-1:0] tmpl,
   input  logic [UOP_BGN_W-1:0] uop_bgn,
   input  logic [UOP_END_W-1:0] uop_end,
   output logic [INS_WIDTH-1:0] insn
);

   always_comb begin
      insn = tmpl;
      insn[UOP_BGN_LSB +: UOP_BGN_W] = uop_bgn;
      insn[UOP_END_LSB +: UOP_END_W] = uop_end;
   end

endmodule

// File: rtl/gemm_uop_loader.sv
// Streams micro-ops into consecutive uop memory slots, then issues the GEMM instruction
// whose uop_bgn/uop_end cover the loaded range.
module gemm_uop_loader
   import gemm_uop_loader_pkg::*;
#(
   parameter int unsigned UOP_WIDTH = 32,
   parameter int unsigned UPC_WIDTH = 13,
   parameter int unsigned INS_WIDTH = 128,
   parameter int unsigned UOP_DEPTH = 8192
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [INS_WIDTH-1:0] cfg_insn,
   input  logic                 s_uop_valid,
   output logic                 s_uop_ready,
   input  logic [UOP_WIDTH-1:0] s_uop_data,
   input  logic                 s_uop_last,
   output logic [UPC_WIDTH-1:0] uop_push_addr,
   output logic [UOP_WIDTH-1:0] uop_push_val,
   output logic                 uop_we,
   output logic                 insn_valid,
   input  logic                 insn_ready,
   output logic [INS_WIDTH-1:0] insn,
   output logic                 busy,
   output logic                 err_overflow
);

   // Pointer is one bit wider than the address so it can hold the exclusive end UOP_DEPTH.
   localparam int unsigned PTR_W = UOP_END_W;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(UOP_DEPTH);

   loader_state_e state_q, state_d;

   logic [INS_WIDTH-1:0] tmpl_q;
   logic [PTR_W-1:0]     ptr_q;
   logic [UPC_WIDTH-1:0] addr_q;
   logic [UOP_WIDTH-1:0] val_q;
   logic                 we_q;
   logic                 err_q;
   logic [INS_WIDTH-1:0] insn_packed;

   logic cfg_fire;
   logic beat_fire;
   logic beat_ovf;

   assign cfg_fire  = cfg_valid & cfg_ready;
   assign beat_fire = s_uop_valid & s_uop_ready;
   assign beat_ovf  = ptr_q >= DEPTH_P;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cfg_valid) state_d = StLoad;
         StLoad:  if (s_uop_valid && s_uop_last) state_d = StFlush;
         StFlush: state_d = StIssue;
         StIssue: if (insn_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cfg_ready   = 1'b0;
      s_uop_ready = 1'b0;
      insn_valid  = 1'b0;
      busy        = 1'b1;
      insn        = '0;
      unique case (state_q)
         StIdle: begin
            cfg_ready = 1'b1;
            busy      = 1'b0;
         end
         StLoad:  s_uop_ready = 1'b1;
         StFlush: ;
         StIssue: begin
            insn_valid = 1'b1;
            insn       = insn_packed;
         end
         default: ;
      endcase
   end

   // Once the pointer reaches UOP_DEPTH it saturates, so all later beats are also dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmpl_q <= '0;
         ptr_q  <= '0;
         addr_q <= '0;
         val_q  <= '0;
         we_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         we_q <= beat_fire & ~beat_ovf;
         if (cfg_fire) begin
            tmpl_q <= cfg_insn;
            ptr_q  <= {1'b0, cfg_insn[UOP_BGN_LSB +: UOP_BGN_W]};
         end
         if (beat_fire) begin
            if (beat_ovf) begin
               err_q <= 1'b1;
               ptr_q <= DEPTH_P;
            end else begin
               addr_q <= ptr_q[UPC_WIDTH-1:0];
               val_q  <= s_uop_data;
               ptr_q  <= ptr_q + PTR_W'(1);
            end
         end
      end
   end

   assign uop_push_addr = addr_q;
   assign uop_push_val  = val_q;
   assign uop_we        = we_q;
   assign err_overflow  = err_q;

   gemm_insn_pack #(
      .INS_WIDTH(INS_WIDTH)
   ) u_pack (
      .tmpl    (tmpl_q),
      .uop_bgn (tmpl_q[UOP_BGN_LSB +: UOP_BGN_W]),
      .uop_end (ptr_q),
      .insn    (insn_packed)
   );

endmodule

// File: tb/tb_gemm_uop_loader.sv
// Directed-plus-random bench for gemm_uop_loader against an arithmetic model of the
// expected writes, overflow flag and issued instruction.
module tb_gemm_uop_loader;

   localparam int unsigned DEPTH = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [127:0] cfg_insn;
   logic         s_uop_valid;
   logic         s_uop_ready;
   logic [31:0]  s_uop_data;
   logic         s_uop_last;
   logic [12:0]  uop_push_addr;
   logic [31:0]  uop_push_val;
   logic         uop_we;
   logic         insn_valid;
   logic         insn_ready;
   logic [127:0] insn;
   logic         busy;
   logic         err_overflow;

   int unsigned tests = 0;
   int unsigned fails = 0;
   bit          err_model = 1'b0;
   logic [31:0] fixed_q[$];

   always #5 clk = ~clk;

   gemm_uop_loader dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_insn      (cfg_insn),
      .s_uop_valid   (s_uop_valid),
      .s_uop_ready   (s_uop_ready),
      .s_uop_data    (s_uop_data),
      .s_uop_last    (s_uop_last),
      .uop_push_addr (uop_push_addr),
      .uop_push_val  (uop_push_val),
      .uop_we        (uop_we),
      .insn_valid    (insn_valid),
      .insn_ready    (insn_ready),
      .insn          (insn),
      .busy          (busy),
      .err_overflow  (err_overflow)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_tmpl(input int unsigned bgn);
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      t[20:8] = 13'(bgn);
      return t;
   endfunction

   function automatic logic [127:0] exp_insn(input logic [127:0] t, input int unsigned n);
      int unsigned e;
      logic [127:0] r;
      e = {19'd0, t[20:8]} + n;
      if (e > DEPTH) e = DEPTH;
      r = t;
      r[34:21] = 14'(e);
      return r;
   endfunction

   task automatic send_cfg(input logic [127:0] t);
      int unsigned k = 0;
      while (!cfg_ready && k < 50) begin
         tick();
         k++;
      end
      chk("cfg_ready_wait", cfg_ready, 1);
      cfg_insn  = t;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("load_entry", s_uop_ready, 1);
   endtask

   // Streams n beats for template t and completes the issue handshake.
   task automatic load_issue(input logic [127:0] t, input int unsigned n, input bit stall,
                             input int unsigned hold, input bit early_rdy,
                             input bit pend_cfg, input logic [127:0] next_t);
      int unsigned b;
      int unsigned a;
      int unsigned g;
      logic [31:0] d;
      bit          wr;
      logic [127:0] ei;
      b  = {19'd0, t[20:8]};
      ei = exp_insn(t, n);
      for (int i = 0; i < int'(n); i++) begin
         if (stall) begin
            g = $urandom_range(0, 2);
            s_uop_valid = 1'b0;
            repeat (g) begin
               tick();
               chk("gap_we", uop_we, 0);
               chk("gap_ready", s_uop_ready, 1);
            end
         end
         a = b + i;
         d = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
         s_uop_data  = d;
         s_uop_last  = (i == int'(n) - 1);
         s_uop_valid = 1'b1;
         if (early_rdy) insn_ready = 1'b1;
         chk("load_ready", s_uop_ready, 1);
         tick();
         wr = a < DEPTH;
         if (!wr) err_model = 1'b1;
         chk("beat_we", uop_we, wr);
         if (wr) begin
            chk("beat_addr", uop_push_addr, a);
            chk("beat_val", uop_push_val, d);
         end
         chk("err_ovf", err_overflow, err_model);
      end
      s_uop_valid = 1'b0;
      s_uop_last  = 1'b0;
      chk("flush_ready", s_uop_ready, 0);
      chk("flush_valid", insn_valid, 0);
      chk("flush_busy", busy, 1);
      tick();
      chk("issue_valid", insn_valid, 1);
      chk("issue_insn", insn, ei);
      chk("issue_ready", s_uop_ready, 0);
      chk("issue_we", uop_we, 0);
      if (pend_cfg) begin
         cfg_insn  = next_t;
         cfg_valid = 1'b1;
      end
      repeat (hold) begin
         tick();
         chk("hold_valid", insn_valid, 1);
         chk("hold_insn", insn, ei);
         chk("hold_cfg_ready", cfg_ready, 0);
      end
      insn_ready = 1'b1;
      tick();
      insn_ready = 1'b0;
      chk("done_valid", insn_valid, 0);
      chk("done_cfg_ready", cfg_ready, 1);
      chk("done_err", err_overflow, err_model);
      if (pend_cfg) begin
         tick();
         cfg_valid = 1'b0;
         chk("pend_accept", s_uop_ready, 1);
         chk("pend_cfg_ready", cfg_ready, 0);
      end
   endtask

   initial begin
      logic [127:0] t;
      logic [127:0] t2;
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_insn    = '0;
      s_uop_valid = 1'b0;
      s_uop_data  = '0;
      s_uop_last  = 1'b0;
      insn_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_uop_ready, 0);
      chk("rst_insn_valid", insn_valid, 0);
      chk("rst_we", uop_we, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_insn", insn, 0);
      chk("rst_addr", uop_push_addr, 0);
      chk("rst_val", uop_push_val, 0);

      // Basic two-beat load at base 0
      t = mk_tmpl(0);
      fixed_q.push_back(32'h0000_0000);
      fixed_q.push_back(32'h0040_0801);
      send_cfg(t);
      load_issue(t, 2, 1'b0, 0, 1'b0, 1'b0, '0);

      // Stalled stream at base 100, long issue backpressure, next command held during ISSUE
      t  = mk_tmpl(100);
      t2 = mk_tmpl($urandom_range(0, 8000));
      send_cfg(t);
      load_issue(t, 5, 1'b1, 7, 1'b0, 1'b1, t2);
      load_issue(t2, 3, 1'b1, 1, 1'b0, 1'b0, '0);

      // Overflow past the top of uop memory
      t = mk_tmpl(8190);
      send_cfg(t);
      load_issue(t, 4, 1'b0, 2, 1'b0, 1'b0, '0);

      // Reset in the middle of a load
      t = mk_tmpl(8191);
      send_cfg(t);
      s_uop_valid = 1'b1;
      s_uop_last  = 1'b0;
      s_uop_data  = $urandom;
      tick();
      tick();
      s_uop_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      err_model = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cfg_ready", cfg_ready, 1);
      chk("mid_rst_insn_valid", insn_valid, 0);
      chk("mid_rst_err", err_overflow, 0);
      chk("mid_rst_we", uop_we, 0);
      t = mk_tmpl($urandom_range(0, 8000));
      send_cfg(t);
      load_issue(t, $urandom_range(1, 6), 1'b1, $urandom_range(0, 3), 1'b0, 1'b0, '0);

      // Single-beat command, insn_ready raised early
      t = mk_tmpl(42);
      send_cfg(t);
      load_issue(t, 1, 1'b0, 0, 1'b1, 1'b0, '0);

      // Random commands anywhere in the address space
      for (int k = 0; k < 6; k++) begin
         t = mk_tmpl($urandom_range(0, DEPTH - 1));
         send_cfg(t);
         load_issue(t, $urandom_range(1, 8), 1'(($urandom & 1)), $urandom_range(0, 3),
                    1'b0, 1'b0, '0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gemm_uop_loader.md
Name: gemm_uop_loader

Overview:
Write-side companion to the GEMM core's micro-op memory. It accepts a command carrying an instruction template, then a valid/ready stream of 32-bit micro-ops, and writes them to consecutive uop memory addresses over the uop push port. Once the last micro-op has landed, it issues the completed 128-bit GEMM instruction, with uop_bgn/uop_end filled in, over a valid/ready handshake. It sits between the instruction fetch/host path and the gemm core plus its uop bram.

Parameters:
UOP_WIDTH, 32, micro-op word width (acc idx [10:0], inp idx [21:11], wgt idx [31:22])
UPC_WIDTH, 13, uop memory address width
INS_WIDTH, 128, GEMM instruction width
UOP_DEPTH, 8192, uop memory entries; must be <= 2**UPC_WIDTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  command template valid
cfg_ready  out  1  loader idle and able to accept a command
cfg_insn  in  INS_WIDTH  template; [20:8] gives the base address; [34:21] is ignored
s_uop_valid  in  1  micro-op beat valid
s_uop_ready  out  1  loader accepting micro-ops
s_uop_data  in  UOP_WIDTH  micro-op word
s_uop_last  in  1  final micro-op of the command
uop_push_addr  out  UPC_WIDTH  uop memory write address
uop_push_val  out  UOP_WIDTH  uop memory write data
uop_we  out  1  uop memory write strobe
insn_valid  out  1  completed instruction valid
insn_ready  in  1  gemm accepts the instruction
insn  out  INS_WIDTH  completed instruction
busy  out  1  high in any state other than IDLE
err_overflow  out  1  sticky overflow flag; cleared only by rst

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE, pointer 0, and every output 0 except cfg_ready=1. Reset mid-command abandons the command with no partial insn issued. Writes already made to uop memory stay in place.
- States: IDLE, LOAD, FLUSH, ISSUE.
- IDLE: cfg_ready=1. On cfg_valid at an edge, latch cfg_insn. Set ptr = bgn = cfg_insn[20:8] and count = 0. Go to LOAD.
- LOAD: s_uop_ready=1 and cfg_ready=0.
  - Each accepted beat (valid & ready at edge N) drives uop_we=1, uop_push_addr=ptr, uop_push_val=data during cycle N+1 (registered, 1-cycle latency).
  - After each accepted beat, ptr increments and count increments.
  - A beat with last=1 moves the state to FLUSH.
- FLUSH: one cycle in which the final uop_we is visible. No handshakes are accepted. Go to ISSUE.
- ISSUE: insn_valid=1, so insn_valid rises 2 cycles after the last-beat handshake and 1 cycle after the last write.
  - insn = latched template with [34:21] = bgn + count (exclusive end, 14-bit, zero-extended sum).
  - insn and insn_valid hold stable until insn_ready. On insn_valid & insn_ready, return to IDLE.
  - insn_ready asserted before insn_valid has no effect.
- uop_we is 0 in every cycle not produced by an accepted beat.
- Overflow: a beat that is accepted when ptr would exceed UOP_DEPTH-1 sets err_overflow=1.
  - That beat's write and every later write of the command are suppressed (uop_we stays 0). The beats are still consumed.
  - The command still completes through ISSUE, with uop_end saturated to UOP_DEPTH.
  - Addresses never wrap.
- Back-to-back beats are accepted one per cycle. s_uop_valid low stalls LOAD indefinitely without timeout.
- Minimum command length is 1 micro-op; last=1 on the first beat gives uop_end = bgn+1.
- s_uop_valid in IDLE/FLUSH/ISSUE is ignored (ready=0). cfg_valid outside IDLE is ignored.

Decomposition:
- Shared package/header, reused by gemm and the benches:
  - instruction field bit positions (opcode, reset_reg, uop_bgn, uop_end, iter_out/in, dst/src/wgt factors)
  - micro-op field positions
  - state encoding localparams
- One natural sub-module: gemm_insn_pack. It is combinational and merges the template with bgn/end into the 128-bit insn, so the same packer serves benches and the future fetch unit.
- The loader's FSM, pointer and write register stay in this block.

Test Plan:
- Basic load: cfg bgn=0. Beats 0x00000000 and 0x00400801 (last on the second) -> uop_we at addr 0 then 1 with matching vals. insn_valid 2 cycles after the last handshake, insn[20:8]=0, insn[34:21]=2, other bits equal the template.
- Nonzero base with a stalled stream: bgn=100, 5 beats with valid gaps -> writes at 100..104 only on accepted beats, uop_end=105, s_uop_ready=0 during FLUSH/ISSUE.
- Backpressure on issue: insn_ready low for 7 cycles -> insn_valid and insn stable the whole time. cfg_ready stays 0 until the cycle after the handshake. A second cfg_valid held during ISSUE is accepted only after return to IDLE.
- Overflow: bgn=8190, 4 beats -> writes at 8190 and 8191 only, err_overflow=1 sticky after the third beat, uop_end=8192, insn still issued.
- Reset mid-LOAD: rst after 2 of 4 beats -> next cycle busy=0, cfg_ready=1, insn_valid=0, err_overflow=0. A fresh command then runs normally.
- Single-beat command with last on the first beat and bgn=42 -> one write at 42, uop_end=43.
